// File: rtl/riscv_pkg.sv
// Shared RV32I decode constants, unit-class encoding and opcode classification helpers.
package riscv_pkg;

  localparam int unsigned XLEN_DEF      = 32;
  localparam int unsigned ROB_WIDTH_DEF = 4;
  localparam int unsigned CDB_PORTS_DEF = 2;
  localparam int unsigned REG_IDX_W     = 5;
  localparam int unsigned OPC_W         = 7;

  localparam logic [OPC_W-1:0] OPC_LUI    = 7'b0110111;
  localparam logic [OPC_W-1:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [OPC_W-1:0] OPC_JAL    = 7'b1101111;
  localparam logic [OPC_W-1:0] OPC_JALR   = 7'b1100111;
  localparam logic [OPC_W-1:0] OPC_BRANCH = 7'b1100011;
  localparam logic [OPC_W-1:0] OPC_LOAD   = 7'b0000011;
  localparam logic [OPC_W-1:0] OPC_STORE  = 7'b0100011;
  localparam logic [OPC_W-1:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [OPC_W-1:0] OPC_OP     = 7'b0110011;

  typedef enum logic [1:0] {
    UNIT_ROB = 2'd0,
    UNIT_RS  = 2'd1,
    UNIT_LSB = 2'd2
  } unit_e;

  // Back-end destination class; unknown opcodes retire straight through the ROB.
  function automatic unit_e unit_of(input logic [OPC_W-1:0] opc);
    unit_e u;
    case (opc)
      OPC_LOAD, OPC_STORE:                                 u = UNIT_LSB;
      OPC_OP, OPC_OP_IMM, OPC_BRANCH, OPC_AUIPC, OPC_JALR: u = UNIT_RS;
      default:                                             u = UNIT_ROB;
    endcase
    return u;
  endfunction

  function automatic logic rs1_used(input logic [OPC_W-1:0] opc);
    return (opc == OPC_OP) || (opc == OPC_OP_IMM) || (opc == OPC_LOAD) ||
           (opc == OPC_STORE) || (opc == OPC_BRANCH) || (opc == OPC_JALR);
  endfunction

  function automatic logic rs2_used(input logic [OPC_W-1:0] opc);
    return (opc == OPC_OP) || (opc == OPC_STORE) || (opc == OPC_BRANCH);
  endfunction

endpackage

// File: rtl/operand_resolver.sv
// Resolves one source operand: x0, register file, CDB snoop, ROB forward, else ROB tag.
module operand_resolver
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN      = XLEN_DEF,
  parameter int unsigned ROB_WIDTH = ROB_WIDTH_DEF,
  parameter int unsigned CDB_PORTS = CDB_PORTS_DEF
) (
  input  logic                          used,
  input  logic [REG_IDX_W-1:0]          idx,
  input  logic                          reg_rdy,
  input  logic [XLEN-1:0]               reg_val,
  input  logic [ROB_WIDTH-1:0]          reg_rob_pos,
  input  logic [CDB_PORTS-1:0]          cdb_valid,
  input  logic [CDB_PORTS*ROB_WIDTH-1:0] cdb_rob_pos,
  input  logic [CDB_PORTS*XLEN-1:0]     cdb_val,
  input  logic                          rob_q_rdy,
  input  logic [XLEN-1:0]               rob_q_val,
  output logic                          rdy_c,
  output logic [XLEN-1:0]               val_c,
  output logic [ROB_WIDTH-1:0]          pos_c
);

  logic            cdb_hit;
  logic [XLEN-1:0] cdb_sel;

  // Lowest-indexed matching broadcast wins.
  always_comb begin
    cdb_hit = 1'b0;
    cdb_sel = '0;
    for (int unsigned p = 0; p < CDB_PORTS; p++) begin
      if (!cdb_hit && cdb_valid[p] &&
          cdb_rob_pos[p*ROB_WIDTH +: ROB_WIDTH] == reg_rob_pos) begin
        cdb_hit = 1'b1;
        cdb_sel = cdb_val[p*XLEN +: XLEN];
      end
    end
  end

  always_comb begin
    rdy_c = 1'b1;
    val_c = '0;
    pos_c = '0;
    if (!used || idx == '0) begin
      rdy_c = 1'b1;
    end else if (reg_rdy) begin
      val_c = reg_val;
    end else if (cdb_hit) begin
      val_c = cdb_sel;
    end else if (rob_q_rdy) begin
      val_c = rob_q_val;
    end else begin
      rdy_c = 1'b0;
      pos_c = reg_rob_pos;
    end
  end

endmodule

// File: rtl/decode_issue.sv
// Registered RV32I decode/issue stage: accepts one instruction per cycle, resolves
// operands, allocates the ROB tail/rename and pulses a routed issue to RS, LSB or ROB.
module decode_issue
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN      = XLEN_DEF,
  parameter int unsigned ROB_WIDTH = ROB_WIDTH_DEF,
  parameter int unsigned CDB_PORTS = CDB_PORTS_DEF
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           rdy,
  input  logic                           rollback,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [31:0]                    inst,
  input  logic [XLEN-1:0]                inst_pc,
  input  logic                           inst_pred_j,
  input  logic                           rob_full,
  input  logic                           rs_full,
  input  logic                           lsb_full,
  input  logic [ROB_WIDTH-1:0]           rob_tail,
  output logic [REG_IDX_W-1:0]           reg_rs1,
  output logic [REG_IDX_W-1:0]           reg_rs2,
  input  logic                           reg_rs1_rdy,
  input  logic [XLEN-1:0]                reg_rs1_val,
  input  logic [ROB_WIDTH-1:0]           reg_rs1_rob_pos,
  input  logic                           reg_rs2_rdy,
  input  logic [XLEN-1:0]                reg_rs2_val,
  input  logic [ROB_WIDTH-1:0]           reg_rs2_rob_pos,
  output logic [ROB_WIDTH-1:0]           rob_q1_pos,
  input  logic                           rob_q1_rdy,
  input  logic [XLEN-1:0]                rob_q1_val,
  output logic [ROB_WIDTH-1:0]           rob_q2_pos,
  input  logic                           rob_q2_rdy,
  input  logic [XLEN-1:0]                rob_q2_val,
  input  logic [CDB_PORTS-1:0]           cdb_valid,
  input  logic [CDB_PORTS*ROB_WIDTH-1:0] cdb_rob_pos,
  input  logic [CDB_PORTS*XLEN-1:0]      cdb_val,
  output logic                           rename_en,
  output logic [REG_IDX_W-1:0]           rename_rd,
  output logic [ROB_WIDTH-1:0]           rename_rob_pos,
  output logic                           out_valid,
  output logic                           rs_en,
  output logic                           lsb_en,
  output logic                           rob_ready,
  output logic [OPC_W-1:0]               opcode,
  output logic [2:0]                     funct3,
  output logic                           funct7,
  output logic [REG_IDX_W-1:0]           rd,
  output logic [XLEN-1:0]                imm,
  output logic [XLEN-1:0]                pc,
  output logic                           pred_j,
  output logic [ROB_WIDTH-1:0]           rob_pos,
  output logic [XLEN-1:0]                result,
  output logic                           rs1_rdy,
  output logic [XLEN-1:0]                rs1_val,
  output logic [ROB_WIDTH-1:0]           rs1_rob_pos,
  output logic                           rs2_rdy,
  output logic [XLEN-1:0]                rs2_val,
  output logic [ROB_WIDTH-1:0]           rs2_rob_pos
);

  logic [OPC_W-1:0]     opc_c;
  unit_e                unit_c;
  logic [XLEN-1:0]      imm_c;
  logic [XLEN-1:0]      result_c;
  logic [REG_IDX_W-1:0] rd_c;
  logic                 accept_c;
  logic                 s1_rdy_c, s2_rdy_c;
  logic [XLEN-1:0]      s1_val_c, s2_val_c;
  logic [ROB_WIDTH-1:0] s1_pos_c, s2_pos_c;

  assign opc_c  = inst[6:0];
  assign unit_c = unit_of(opc_c);

  // Immediate, destination and ROB-only result decode.
  always_comb begin
    imm_c    = '0;
    result_c = '0;
    rd_c     = inst[11:7];
    case (opc_c)
      OPC_OP_IMM, OPC_LOAD, OPC_JALR:
        imm_c = {{(XLEN-12){inst[31]}}, inst[31:20]};
      OPC_STORE: begin
        imm_c = {{(XLEN-12){inst[31]}}, inst[31:25], inst[11:7]};
        rd_c  = '0;
      end
      OPC_BRANCH: begin
        imm_c = {{(XLEN-13){inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
        rd_c  = '0;
      end
      OPC_AUIPC:
        imm_c = {{(XLEN-32){inst[31]}}, inst[31:12], 12'b0};
      OPC_LUI: begin
        imm_c    = {{(XLEN-32){inst[31]}}, inst[31:12], 12'b0};
        result_c = imm_c;
      end
      OPC_JAL: begin
        imm_c    = {{(XLEN-21){inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
        result_c = inst_pc + XLEN'(4);
      end
      OPC_OP: ;
      default: rd_c = '0;
    endcase
  end

  assign in_ready = rdy & ~rollback & ~rob_full &
                    ~((unit_c == UNIT_RS) & rs_full) &
                    ~((unit_c == UNIT_LSB) & lsb_full);
  assign accept_c = in_valid & in_ready;

  assign rename_en      = accept_c & (rd_c != '0);
  assign rename_rd      = rd_c;
  assign rename_rob_pos = rob_tail;

  assign reg_rs1    = inst[19:15];
  assign reg_rs2    = inst[24:20];
  assign rob_q1_pos = reg_rs1_rob_pos;
  assign rob_q2_pos = reg_rs2_rob_pos;

  operand_resolver #(.XLEN(XLEN), .ROB_WIDTH(ROB_WIDTH), .CDB_PORTS(CDB_PORTS)) u_res1 (
    .used(rs1_used(opc_c)), .idx(inst[19:15]),
    .reg_rdy(reg_rs1_rdy), .reg_val(reg_rs1_val), .reg_rob_pos(reg_rs1_rob_pos),
    .cdb_valid(cdb_valid), .cdb_rob_pos(cdb_rob_pos), .cdb_val(cdb_val),
    .rob_q_rdy(rob_q1_rdy), .rob_q_val(rob_q1_val),
    .rdy_c(s1_rdy_c), .val_c(s1_val_c), .pos_c(s1_pos_c)
  );

  operand_resolver #(.XLEN(XLEN), .ROB_WIDTH(ROB_WIDTH), .CDB_PORTS(CDB_PORTS)) u_res2 (
    .used(rs2_used(opc_c)), .idx(inst[24:20]),
    .reg_rdy(reg_rs2_rdy), .reg_val(reg_rs2_val), .reg_rob_pos(reg_rs2_rob_pos),
    .cdb_valid(cdb_valid), .cdb_rob_pos(cdb_rob_pos), .cdb_val(cdb_val),
    .rob_q_rdy(rob_q2_rdy), .rob_q_val(rob_q2_val),
    .rdy_c(s2_rdy_c), .val_c(s2_val_c), .pos_c(s2_pos_c)
  );

  // Issue register: pulse bits follow accept; payload only loads on accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid   <= 1'b0;
      rs_en       <= 1'b0;
      lsb_en      <= 1'b0;
      rob_ready   <= 1'b0;
      opcode      <= '0;
      funct3      <= '0;
      funct7      <= 1'b0;
      rd          <= '0;
      imm         <= '0;
      pc          <= '0;
      pred_j      <= 1'b0;
      rob_pos     <= '0;
      result      <= '0;
      rs1_rdy     <= 1'b1;
      rs1_val     <= '0;
      rs1_rob_pos <= '0;
      rs2_rdy     <= 1'b1;
      rs2_val     <= '0;
      rs2_rob_pos <= '0;
    end else if (rdy) begin
      out_valid <= accept_c;
      rs_en     <= accept_c & (unit_c == UNIT_RS);
      lsb_en    <= accept_c & (unit_c == UNIT_LSB);
      rob_ready <= accept_c & (unit_c == UNIT_ROB);
      if (accept_c) begin
        opcode      <= opc_c;
        funct3      <= inst[14:12];
        funct7      <= inst[30];
        rd          <= rd_c;
        imm         <= imm_c;
        pc          <= inst_pc;
        pred_j      <= inst_pred_j;
        rob_pos     <= rob_tail;
        result      <= result_c;
        rs1_rdy     <= s1_rdy_c;
        rs1_val     <= s1_val_c;
        rs1_rob_pos <= s1_pos_c;
        rs2_rdy     <= s2_rdy_c;
        rs2_val     <= s2_val_c;
        rs2_rob_pos <= s2_pos_c;
      end
    end
  end

endmodule

// File: doc/decode_issue.md
# decode_issue

Registered decode-and-issue stage between the instruction fetch unit and the back end (RS, LSB, ROB, register file). Each cycle it accepts at most one instruction through a valid/ready handshake and decodes all RV32I formats. It resolves each source operand from the register file, CDB snoop or ROB forwarding, and allocates the ROB tail and rename for `rd`. It emits a one-cycle issue pulse routed to RS, LSB or ROB-only. It stalls on downstream full and flushes on rollback.

## Interface
- `XLEN`, 32, data/address width
- `ROB_WIDTH`, 4, ROB index width (ROB depth 2**ROB_WIDTH)
- `CDB_PORTS`, 2, number of result broadcast channels snooped (ALU, LSB, ...)

- `clk` in 1: clock
- `rst` in 1: reset; synchronous, active-high
- `rdy` in 1: global enable; when low, all state holds
- `rollback` in 1: misprediction flush
- `in_valid` in 1: fetch presents an instruction
- `in_ready` out 1: instruction accepted this cycle
- `inst` in 32, `inst_pc` in XLEN, `inst_pred_j` in 1: fetched instruction, its PC, branch-predicted-taken
- `rob_full`, `rs_full`, `lsb_full` in 1 each: downstream capacity
- `rob_tail` in ROB_WIDTH: ROB slot allocated on accept
- `reg_rs1`, `reg_rs2` out 5: register file query indices
- `reg_rsN_rdy` in 1, `reg_rsN_val` in XLEN, `reg_rsN_rob_pos` in ROB_WIDTH (N=1,2): register file answer
- `rob_qN_pos` out ROB_WIDTH, `rob_qN_rdy` in 1, `rob_qN_val` in XLEN: ROB forwarding query
- `cdb_valid` in CDB_PORTS, `cdb_rob_pos` in CDB_PORTS*ROB_WIDTH, `cdb_val` in CDB_PORTS*XLEN: flattened broadcast channels
- `rename_en` out 1, `rename_rd` out 5, `rename_rob_pos` out ROB_WIDTH: combinational rename request, asserted on the accept cycle
- `out_valid`, `rs_en`, `lsb_en`, `rob_ready` out 1: registered issue pulse and routing
- `opcode` 7, `funct3` 3, `funct7` 1 (inst[30]), `rd` 5, `imm` XLEN, `pc` XLEN, `pred_j` 1, `rob_pos` ROB_WIDTH, `result` XLEN: registered fields
- `rsN_rdy` 1, `rsN_val` XLEN, `rsN_rob_pos` ROB_WIDTH (N=1,2): registered resolved operands

## Operation
- Accept condition: `in_ready = rdy & ~rollback & ~rob_full & ~(needs_rs & rs_full) & ~(needs_lsb & lsb_full)`. The condition is combinational on `inst`. Accept = `in_valid & in_ready`.
- Routing:
  - LOAD, STORE → `lsb_en`.
  - OP, OP-IMM, BRANCH, AUIPC, JALR → `rs_en`.
  - LUI, JAL → `rob_ready=1`, with `result` = imm (LUI) or pc+4 (JAL).
  - Unknown opcode → `rob_ready=1`, `rd=0`, `result=0`.
- Immediates, sign-extended to XLEN:
  - I-type: inst[31:20].
  - S-type: {inst[31:25],inst[11:7]}.
  - B-type: {inst[31],inst[7],inst[30:25],inst[11:8],0}.
  - U-type: {inst[31:12],12'b0}.
  - J-type: {inst[31],inst[19:12],inst[20],inst[30:21],0}.
  - R-type: 0.
- `rd` is forced 0 for STORE and BRANCH.
- Unused sources resolve to rdy=1, val=0, pos=0:
  - rs2 unused for LOAD, OP-IMM, JALR.
  - rs1 and rs2 unused for LUI, AUIPC, JAL.
- Source resolution, per operand, first match wins:
  1. Index x0 → ready, 0.
  2. Register file ready → its value.
  3. CDB port with `cdb_valid` and pos == `reg_rob_pos` → that value (lowest port index wins).
  4. ROB query ready → `rob_qN_val`.
  5. Otherwise → not ready, with `rob_pos`.
- Rename: `rename_en = accept & rd!=0`. The register file reflects the rename from the next cycle, so back-to-back dependents see the new tag.

## Timing
- Decode latency is 1 cycle. Accept at edge k produces `out_valid` high for exactly cycle k+1.
- Throughput is 1 instruction/cycle.
- Consumers must snoop the CDB themselves in the cycle they latch `out_valid`. This block covers broadcasts only up to the accept edge.
- `rollback`: `in_ready=0`, and `out_valid` is 0 in the following cycle even if an accept was pending. No rename is issued.
- `rdy` low: no accept, and outputs hold their values. `out_valid` is not re-pulsed.
- Reset: every registered output is 0, except `rs1_rdy`=`rs2_rdy`=1. `rst` mid-stream drops the pending issue.
- Simultaneous full and rollback: rollback dominates, and nothing issues.

## Structure
- Shared package `riscv_pkg`: opcode constants, unit-class encoding, ROB/CDB width localparams.
- Sub-module `operand_resolver`: instantiated once per source. Parameterised on `XLEN`, `ROB_WIDTH` and `CDB_PORTS`; implements the priority chain.

## Test plan
- `addi x5,x0,7` at pc 0x100, all empty → `out_valid` next cycle, `rs_en=1`, `imm=7`, `rs1_rdy=1`/`val=0`, `rename` x5→`rob_tail`.
- `sw x2,-4(x3)` → `lsb_en=1`, `rd=0`, `imm=0xFFFFFFFC`, no rename.
- `add x1,x2,x3` with x2 busy at pos 3 and CDB port 1 broadcasting pos 3 val 0x55 in the same cycle → `rs1_rdy=1`, `rs1_val=0x55`. With no broadcast but ROB pos 3 ready with 0x66 → `rs1_val=0x66`.
- `jal x1,+8` at pc 0x200 → `rob_ready=1`, `result=0x204`, `imm=8`; `lui x4,0x12345` → `result=0x12345000`.
- `lw` with `lsb_full=1` → `in_ready=0` until `lsb_full` drops, then issues once. `rollback` asserted on the accept cycle → no `out_valid`, no rename.
